// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: funct codes and FSM encoding.
package mips_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StFix  = 2'b10
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide unit signal bundle; the pipeline is master, the unit is slave.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             read_hilo;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, funct, rs_data, rt_data, read_hilo,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, funct, rs_data, rt_data, read_hilo,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_iter.sv
// One radix-2 step: shift-add multiply or restoring divide on a {high, low} accumulator.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    output logic [2*WIDTH-1:0] acc_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, operand_i};
        if (is_div_i) begin
            // Remainder stays below the divisor, so diff[WIDTH] is a true sign bit.
            if (!diff[WIDTH]) begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Multiplier bits shift out of the low half as the product shifts in.
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide with HI/LO: IDLE latches magnitudes, RUN iterates WIDTH times,
// FIX restores signs and commits HI/LO.
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    muldiv_state_e      state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               is_long, is_signed, is_div_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc_iter;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    always_comb begin
        is_div_op = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_DIVU);
        is_signed = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_MULT);
        is_long   = is_div_op || (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_MULTU);
        a_neg     = is_signed & bus.rs_data[WIDTH-1];
        b_neg     = is_signed & bus.rt_data[WIDTH-1];
        a_mag     = a_neg ? -bus.rs_data : bus.rs_data;
        b_mag     = b_neg ? -bus.rt_data : bus.rt_data;
    end

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .operand_i(opnd_q),
        .acc_o    (acc_iter)
    );

    always_comb begin
        prod_fix = neg_lo_q ? -acc_q : acc_q;
        quot_fix = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (is_long) begin
                        state_d  = StRun;
                        cnt_d    = CntW'(WIDTH - 1);
                        is_div_d = is_div_op;
                        opnd_d   = is_div_op ? b_mag : a_mag;
                        acc_d    = {{WIDTH{1'b0}}, (is_div_op ? a_mag : b_mag)};
                        // A zero divisor keeps the all-ones quotient unsigned-looking.
                        neg_lo_d = (a_neg ^ b_neg) & (!is_div_op || (bus.rt_data != '0));
                        neg_hi_d = is_div_op & a_neg;
                    end else if (bus.funct == FUNCT_MTHI) begin
                        hi_d = bus.rs_data;
                    end else if (bus.funct == FUNCT_MTLO) begin
                        lo_d = bus.rs_data;
                    end
                end
            end
            StRun: begin
                acc_d = acc_iter;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy  = (state_q != StIdle);
    assign bus.stall = bus.busy & (bus.start | bus.read_hilo);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised bench for muldiv_sequencer against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;
    import mips_pkg::*;

    localparam int unsigned W = 32;
    localparam logic [34:0] BUSY_MASK = 35'h3_FFFF_FFFE;
    localparam logic [34:0] DONE_MASK = 35'h4_0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] m_hi, m_lo;
    logic [5:0]  op_functs [6];

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural result of one instruction on the HI/LO model.
    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output bit is_long);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        int unsigned     ua, ub;
        is_long = 1'b0;
        sa = a; sb = b; ua = a; ub = b;
        case (f)
            FUNCT_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {m_hi, m_lo} = sp;
                is_long = 1'b1;
            end
            FUNCT_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                {m_hi, m_lo} = up;
                is_long = 1'b1;
            end
            FUNCT_DIV: begin
                if (b == 0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_hi = 32'h0; m_lo = 32'h8000_0000;
                end else begin
                    m_lo = sa / sb; m_hi = sa % sb;
                end
                is_long = 1'b1;
            end
            FUNCT_DIVU: begin
                if (b == 0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF;
                end else begin
                    m_lo = ua / ub; m_hi = ua % ub;
                end
                is_long = 1'b1;
            end
            FUNCT_MTHI: m_hi = a;
            FUNCT_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] pick_val();
        logic [31:0] edges [5];
        edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Issue one instruction in the current cycle; junk starts and reads hit the busy window.
    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bit          is_long;
        logic [34:0] busy_m, done_m, stall_m, stall_x;
        model(f, a, b, is_long);
        bus.start = 1'b1; bus.funct = f; bus.rs_data = a; bus.rt_data = b; bus.read_hilo = 1'b0;
        #1;
        check_eq("stall_accept", 64'(bus.stall), 64'(0));
        tick();
        bus.start = 1'b0;
        if (is_long) begin
            busy_m = '0; done_m = '0; stall_m = '0; stall_x = '0;
            for (int c = 1; c <= 34; c++) begin
                if (c <= 33 && $urandom_range(0, 3) == 0) begin
                    bus.start   = 1'b1;
                    bus.funct   = op_functs[$urandom_range(0, 3)];
                    bus.rs_data = $urandom;
                    bus.rt_data = $urandom;
                end else begin
                    bus.start = 1'b0;
                end
                bus.read_hilo = (c <= 33) ? ($urandom_range(0, 2) == 0) : 1'b0;
                stall_x[c] = (c <= 33) && (bus.start || bus.read_hilo);
                #1;
                busy_m[c]  = bus.busy;
                done_m[c]  = bus.done;
                stall_m[c] = bus.stall;
                if (c < 34) tick();
            end
            bus.start = 1'b0; bus.read_hilo = 1'b0;
            check_eq("busy_window", 64'(busy_m), 64'(BUSY_MASK));
            check_eq("done_pulse", 64'(done_m), 64'(DONE_MASK));
            check_eq("stall_window", 64'(stall_m), 64'(stall_x));
            check_eq("hi", 64'(bus.hi), 64'(m_hi));
            check_eq("lo", 64'(bus.lo), 64'(m_lo));
            tick();
            check_eq("done_clear", 64'(bus.done), 64'(0));
        end else begin
            check_eq("short_hi", 64'(bus.hi), 64'(m_hi));
            check_eq("short_lo", 64'(bus.lo), 64'(m_lo));
            check_eq("short_busy", 64'(bus.busy), 64'(0));
            check_eq("short_done", 64'(bus.done), 64'(0));
        end
    endtask

    initial begin
        logic [34:0] stall_m;
        bit          seen_done;
        bit          dummy;
        op_functs = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO};
        m_hi = '0; m_lo = '0;
        bus.start = 1'b0; bus.funct = '0; bus.rs_data = '0; bus.rt_data = '0;
        bus.read_hilo = 1'b0;
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        bus.read_hilo = 1'b1;
        #1;
        check_eq("rst_busy", 64'(bus.busy), 64'(0));
        check_eq("rst_done", 64'(bus.done), 64'(0));
        check_eq("rst_hi", 64'(bus.hi), 64'(0));
        check_eq("rst_lo", 64'(bus.lo), 64'(0));
        check_eq("rst_stall", 64'(bus.stall), 64'(0));
        bus.read_hilo = 1'b0;
        tick();

        do_op(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_eq("multu_max_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
        check_eq("multu_max_lo", 64'(bus.lo), 64'h0000_0000_0000_0001);
        do_op(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
        check_eq("div_neg7_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
        check_eq("div_neg7_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
        do_op(FUNCT_DIVU, 32'd7, 32'd0);
        check_eq("divu_zero_hi", 64'(bus.hi), 64'h7);
        check_eq("divu_zero_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFF);
        do_op(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("div_ovf_lo", 64'(bus.lo), 64'h0000_0000_8000_0000);
        check_eq("div_ovf_hi", 64'(bus.hi), 64'h0);
        do_op(FUNCT_DIV, 32'hFFFF_FFF9, 32'd0);

        // mult -3 x 5 with a pending read from cycle 5 and an ignored start at cycle 10
        model(FUNCT_MULT, 32'hFFFF_FFFD, 32'd5, dummy);
        bus.start = 1'b1; bus.funct = FUNCT_MULT; bus.rs_data = 32'hFFFF_FFFD; bus.rt_data = 32'd5;
        tick();
        stall_m = '0;
        for (int c = 1; c <= 34; c++) begin
            bus.read_hilo = (c >= 5);
            bus.start     = (c == 10);
            bus.funct     = FUNCT_DIVU;
            bus.rs_data   = 32'd100;
            bus.rt_data   = 32'd3;
            #1;
            stall_m[c] = bus.stall;
            if (c < 34) tick();
        end
        check_eq("stall_read", 64'(stall_m), 64'h3_FFFF_FFE0);
        check_eq("mult_neg_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
        check_eq("mult_neg_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFF1);
        check_eq("ignored_hi", 64'(bus.hi), 64'(m_hi));
        bus.read_hilo = 1'b0; bus.start = 1'b0;
        tick();

        // Reset in cycle 12 of a divide
        bus.start = 1'b1; bus.funct = FUNCT_DIV; bus.rs_data = 32'd1000; bus.rt_data = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (11) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        check_eq("midrst_busy", 64'(bus.busy), 64'(0));
        check_eq("midrst_hi", 64'(bus.hi), 64'(0));
        check_eq("midrst_lo", 64'(bus.lo), 64'(0));
        seen_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus.done) seen_done = 1'b1;
            tick();
        end
        check_eq("midrst_no_done", 64'(seen_done), 64'(0));
        do_op(FUNCT_MULT, 32'd123456, 32'hFFFF_FF00);

        // mthi then mtlo back to back
        m_hi = 32'h1234_5678;
        bus.start = 1'b1; bus.funct = FUNCT_MTHI; bus.rs_data = 32'h1234_5678;
        tick();
        bus.funct = FUNCT_MTLO; bus.rs_data = 32'h9ABC_DEF0;
        #1;
        check_eq("mthi_hi", 64'(bus.hi), 64'h1234_5678);
        check_eq("mt_busy", 64'(bus.busy), 64'(0));
        check_eq("mt_stall", 64'(bus.stall), 64'(0));
        check_eq("mt_done", 64'(bus.done), 64'(0));
        tick();
        bus.start = 1'b0;
        m_lo = 32'h9ABC_DEF0;
        check_eq("mtlo_lo", 64'(bus.lo), 64'h9ABC_DEF0);
        check_eq("mtlo_hi_kept", 64'(bus.hi), 64'h1234_5678);
        tick();

        for (int i = 0; i < 50; i++) begin
            int unsigned k;
            k = $urandom_range(0, 7);
            if (k < 6) do_op(op_functs[k], pick_val(), pick_val());
            else do_op(6'($urandom_range(0, 15)), pick_val(), pick_val());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative 32-bit multiply/divide unit with HI/LO registers, sequenced by an internal FSM. It sits beside the ALU in the EX stage and handles `mult`, `multu`, `div`, `divu`, `mthi`, `mtlo`. It holds the pipeline through a stall output while an operation is in flight, and while a HI/LO read is pending against a busy unit. The ALU control path decodes these functs as R-type; this block owns their execution.

## Interface
Parameters:
- `WIDTH`, 32: operand/HI/LO width; the iteration count equals `WIDTH`.

Ports:
- `clk`, in, 1: single clock, all state updates on rising edge.
- `reset`, in, 1: synchronous, active-low.
- `start`, in, 1: EX stage holds a mul/div/mt instruction this cycle.
- `funct`, in, 6: R-type funct field.
- `rs_data`, in, `WIDTH`: dividend/multiplicand, or mthi/mtlo source.
- `rt_data`, in, `WIDTH`: divisor/multiplier.
- `read_hilo`, in, 1: EX stage holds `mfhi`/`mflo`.
- `busy`, out, 1: operation in progress.
- `stall`, out, 1: freeze PC/IF/ID/EX this cycle.
- `done`, out, 1: one-cycle pulse when the result is committed.
- `hi`, out, `WIDTH`: HI register.
- `lo`, out, `WIDTH`: LO register.

## Operation
- Funct codes:
  - `011000` mult, `011001` multu, `011010` div, `011011` divu: long ops.
  - `010001` mthi, `010011` mtlo: short ops.
  - Any other funct with `start` is ignored.
- FSM states: IDLE, RUN, FIX.
- IDLE, `start`, long op:
  - Latch operand magnitudes (`|x|` for signed ops, raw for unsigned).
  - Latch result-sign flags and op type.
  - Counter = `WIDTH`-1; go to RUN.
- IDLE, `start`, mthi/mtlo: write `rs_data` to `hi`/`lo` at that edge. Stay in IDLE, no `busy`, no `done`.
- RUN, one iteration per cycle:
  - Multiply: radix-2 shift-add into a 2·`WIDTH` accumulator.
  - Divide: restoring; shift remainder:quotient left, subtract divisor, keep if non-negative.
  - At counter 0 go to FIX.
- FIX, one cycle:
  - mult: negate the 64-bit product if operand signs differ.
  - div: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Write `hi` (product high / remainder) and `lo` (product low / quotient) at the FIX→IDLE edge.
- Divide by zero (divisor == 0, div or divu): `hi` = `rs_data` as latched, `lo` = all ones. Runs the full latency.
- Signed `0x80000000 / -1`: `lo` = `0x80000000`, `hi` = 0. No trap.
- `start` while not IDLE: ignored. No queueing; the pipeline is stalled, so the instruction re-presents.
- Reset, at any time including mid-RUN, at the next edge:
  - State returns to IDLE.
  - Counter, operand and accumulator registers are cleared.
  - `hi` = `lo` = 0, `busy` = 0, `done` = 0.
  - The in-flight op is discarded.

## Timing
- Reset values: `busy` 0, `done` 0, `hi` 0, `lo` 0, `stall` 0.
- Long op accepted at edge E0 (cycle 0):
  - `busy` = 1 for cycles 1..`WIDTH`+1 (RUN × 32, FIX × 1).
  - `hi`/`lo` new from cycle `WIDTH`+2 (34).
  - `done` = 1 in cycle 34 only.
  - Next long op can be accepted at the end of cycle 34.
- `stall` is combinational: `busy & (start | read_hilo)`. It is 0 in IDLE.
  - A back-to-back long op or an `mfhi`/`mflo` behind a long op waits.
  - The read in cycle 34 sees the new value.
- `busy` and `done` are registered (state-derived).
- mthi/mtlo latency: 1 edge; visible the next cycle.

## Structure
- Shared package `mips_pkg`:
  - funct localparams (`FUNCT_MULT`, `FUNCT_MULTU`, `FUNCT_DIV`, `FUNCT_DIVU`, `FUNCT_MTHI`, `FUNCT_MTLO`).
  - FSM state encoding (IDLE = 2'b00, RUN = 2'b01, FIX = 2'b10).
- One sub-module, `muldiv_iter`: the per-cycle shift-add/restoring-subtract step, purely combinational.
- The FSM, counter, sign handling and HI/LO live in `muldiv_sequencer`.
- Target size: roughly 150–250 lines total.

## Test plan
- multu `0xFFFFFFFF` × `0xFFFFFFFF`, start at cycle 0 → `busy` for cycles 1–33; `done` at 34; `hi` = `0xFFFFFFFE`, `lo` = `0x00000001`.
- mult −3 × 5 → `hi` = `0xFFFFFFFF`, `lo` = `0xFFFFFFF1`. div −7 / 2 → `lo` = `0xFFFFFFFD`, `hi` = `0xFFFFFFFF`.
- divu 7 / 0 → after 34 cycles, `hi` = `0x00000007`, `lo` = `0xFFFFFFFF`. Signed `0x80000000` / −1 → `lo` = `0x80000000`, `hi` = 0.
- mult in flight with `read_hilo` = 1 from cycle 5 → `stall` = 1 in cycles 5–33, 0 in cycle 34. A second `start` at cycle 10 is ignored; `hi`/`lo` reflect only the first op.
- `reset` low for one edge at cycle 12 of a div → next cycle: IDLE, `busy` 0, `hi` = `lo` = 0, no `done` pulse follows. A new op accepted afterward completes normally.
- mthi `0x12345678` then mtlo `0x9ABCDEF0` on consecutive cycles → `hi`/`lo` updated one cycle after each; `busy`/`stall`/`done` stay 0.
